// File: rtl/spi_feed_pkg.sv
// Shared types and widths for the SPI transmit feeder; no logic, no latency.
// Imported by the bus interface, the word FIFO and the feeder top.
package spi_feed_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_END,
    GAP
  } feed_state_t;

  // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Host write port, chip-select inputs and status outputs of the feeder.
// The feeder takes the slave modport; the host/bench side takes master.
interface spi_tx_feeder_if #(
  parameter int DATA_W = spi_feed_pkg::DATA_W_DEF,
  parameter int DEPTH  = spi_feed_pkg::DEPTH_DEF
);
  import spi_feed_pkg::*;

  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;
  logic                    spi_cs1_l;
  logic                    spi_cs2_l;
  logic [DATA_W-1:0]       datain;
  logic                    full;
  logic                    empty;
  logic [lvl_w(DEPTH)-1:0] level;
  logic                    busy;
  logic [CNT_W-1:0]        sent_cnt;
  logic                    overflow;
  logic                    timeout_err;

  modport master (
    output wr_en, wr_data, spi_cs1_l, spi_cs2_l,
    input  datain, full, empty, level, busy, sent_cnt, overflow, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, spi_cs1_l, spi_cs2_l,
    output datain, full, empty, level, busy, sent_cnt, overflow, timeout_err
  );

endinterface

// File: rtl/spi_feed_fifo.sv
// Circular word buffer: write lands one edge after i_wr_en, popped word is registered on o_rd_data.
// No backpressure: writes while full are dropped and flagged on o_drop; pops while empty are ignored.
module spi_feed_fifo
  import spi_feed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wr_en,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_drop,
  output logic [lvl_w(DEPTH)-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_rd_data;
  // Full is judged before the edge, so a same-edge pop never rescues a write.
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_drop    = i_wr_en && o_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Holds one queued word on datain per SPI transaction; word appears two edges after wr_en rises into an empty idle FIFO.
// Host writes are never stalled (full drops and sets overflow); optional start timeout via SPI_TX_FEEDER_TIMEOUT_EN.
module spi_tx_feeder
  import spi_feed_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int IDLE_GAP      = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  spi_tx_feeder_if.slave bus
);

  localparam int LVL_W   = lvl_w(DEPTH);
  localparam int GAP_W   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam bit HAS_GAP = (IDLE_GAP > 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_tx_feeder: DEPTH must be a power of 2 and at least 2");
  end
  if (START_TIMEOUT < 1) begin : g_bad_timeout
    $error("spi_tx_feeder: START_TIMEOUT must be at least 1");
  end

  feed_state_t       r_state;
  feed_state_t       w_state_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic [CNT_W-1:0]  r_sent_cnt;
  logic              r_overflow;
  logic              w_pop;
  logic              w_done;
  logic              w_cs_active;
  logic              w_empty;
  logic              w_full;
  logic              w_drop;
  logic [LVL_W-1:0]  w_level;
  logic [DATA_W-1:0] w_rd_data;

  assign w_cs_active = !bus.spi_cs1_l || !bus.spi_cs2_l;

  spi_feed_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (bus.wr_en),
    .i_wr_data (bus.wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_drop    (w_drop),
    .o_level   (w_level)
  );

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;
  logic             w_tmo_hit;
  logic             w_tmo;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(START_TIMEOUT - 1));

  // Counter idles at zero outside WAIT_START, so it is clear on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == WAIT_START && !w_cs_active) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_tmo) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    w_tmo       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = WAIT_START;
        end
      end
      WAIT_START: begin
        if (w_cs_active) begin
          w_state_nxt = WAIT_END;
        end
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = HAS_GAP ? GAP : IDLE;
          w_gap_nxt   = GAP_LOAD;
        end
`endif
      end
      WAIT_END: begin
        // Only both chip-selects high ends the transaction; a lone rise is a glitch.
        if (!w_cs_active) begin
          w_done      = 1'b1;
          w_state_nxt = HAS_GAP ? GAP : IDLE;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_sent_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_done) begin
        r_sent_cnt <= r_sent_cnt + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.datain   = w_rd_data;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.level    = w_level;
  assign bus.busy     = (r_state != IDLE);
  assign bus.sent_cnt = r_sent_cnt;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed-sequence bench with random word data, checked against a queue model of the feeder.
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
`timescale 1ns/1ps
module tb_spi_tx_feeder;
  import spi_feed_pkg::*;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 2;
  localparam int TMO     = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spi_tx_feeder_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  spi_tx_feeder #(
    .DATA_W        (DW),
    .DEPTH         (DEPTH),
    .IDLE_GAP      (GAP_CYC),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: words accepted but not yet presented, the word on datain, counters.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dat;
  int            m_sent;
  bit            m_ovf;
  bit            stable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back writes starting from an idle feeder with an empty FIFO:
  // the first word is popped on the edge that takes the second write.
  task automatic write_burst(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      bus.wr_en   = 1'b1;
      bus.wr_data = w;
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(w);
      if (i == 1) m_dat = q.pop_front();
      tick();
    end
    bus.wr_en = 1'b0;
    if (n == 1) begin
      tick();
      m_dat = q.pop_front();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      tick();
    end
    chk(tag, bus.busy, 1'b0);
  endtask

  task automatic run_txn(input bit on_cs2, input int len);
    if (on_cs2) bus.spi_cs2_l = 1'b0;
    else bus.spi_cs1_l = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      if (bus.datain !== m_dat) stable = 1'b0;
    end
    bus.spi_cs1_l = 1'b1;
    bus.spi_cs2_l = 1'b1;
    m_sent++;
    wait_idle("txn_idle");
    chk("txn_stable", stable, 1'b1);
    chk("txn_sent", bus.sent_cnt, m_sent);
    if (q.size() > 0) begin
      tick();
      m_dat = q.pop_front();
      chk("next_word", bus.datain, m_dat);
      chk("next_level", bus.level, q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.spi_cs1_l = 1'b1;
    bus.spi_cs2_l = 1'b1;
    m_dat  = '0;
    m_sent = 0;
    m_ovf  = 1'b0;

    #12;
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_level", bus.level, 0);
    chk("rst_datain", bus.datain, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sent", bus.sent_cnt, 0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_tmo", bus.timeout_err, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Single word: write edge, then pop edge.
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hA5A5;
    q.push_back(16'hA5A5);
    tick();
    bus.wr_en = 1'b0;
    chk("wr_level", bus.level, 1);
    chk("wr_busy", bus.busy, 1'b0);
    tick();
    m_dat = q.pop_front();
    chk("pop_datain", bus.datain, m_dat);
    chk("pop_busy", bus.busy, 1'b1);
    chk("pop_level", bus.level, 0);

    // 20-cycle transaction on cs1, then exact gap timing.
    bus.spi_cs1_l = 1'b0;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (bus.datain !== m_dat) stable = 1'b0;
    end
    chk("cs1_stable", stable, 1'b1);
    bus.spi_cs1_l = 1'b1;
    m_sent++;
    tick();
    chk("sent_after_rise", bus.sent_cnt, m_sent);
    chk("gap_busy", bus.busy, 1'b1);
    repeat (GAP_CYC - 1) begin
      tick();
      chk("gap_busy", bus.busy, 1'b1);
    end
    tick();
    chk("gap_release", bus.busy, 1'b0);

    // Six writes with no chip-select activity: sixth is dropped.
    write_burst(6);
    chk("ovf_flag", bus.overflow, m_ovf);
    chk("ovf_level", bus.level, q.size());
    chk("ovf_full", bus.full, 1'b1);
    chk("ovf_datain", bus.datain, m_dat);
    for (int t = 0; t < 5; t++) run_txn(1'b1, 3 + t);
    chk("drain_empty", bus.empty, 1'b1);
    chk("drain_hold", bus.datain, m_dat);
    chk("drain_ovf_sticky", bus.overflow, m_ovf);

    // Glitch on cs2 while cs1 is still low must not complete.
    write_burst(1);
    chk("glitch_datain", bus.datain, m_dat);
    bus.spi_cs1_l = 1'b0;
    repeat (3) tick();
    bus.spi_cs2_l = 1'b0;
    repeat (2) tick();
    bus.spi_cs2_l = 1'b1;
    repeat (3) tick();
    chk("glitch_sent", bus.sent_cnt, m_sent);
    chk("glitch_busy", bus.busy, 1'b1);
    bus.spi_cs1_l = 1'b1;
    m_sent++;
    tick();
    chk("glitch_done", bus.sent_cnt, m_sent);
    wait_idle("glitch_idle");

    // Asynchronous reset in WAIT_END with three words queued.
    write_burst(4);
    bus.spi_cs1_l = 1'b0;
    repeat (2) tick();
    chk("pre_rst_level", bus.level, q.size());
    #2 reset = 1'b0;
    #1;
    q.delete();
    m_dat  = '0;
    m_sent = 0;
    m_ovf  = 1'b0;
    chk("arst_datain", bus.datain, m_dat);
    chk("arst_level", bus.level, q.size());
    chk("arst_empty", bus.empty, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_sent", bus.sent_cnt, m_sent);
    chk("arst_ovf", bus.overflow, m_ovf);
    bus.spi_cs1_l = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (bus.datain !== m_dat || bus.busy !== 1'b0) stable = 1'b0;
    end
    chk("post_rst_quiet", stable, 1'b1);

    // One word, chip-select never asserted.
    write_burst(1);
    chk("tmo_datain", bus.datain, m_dat);
    repeat (TMO + GAP_CYC + 20) tick();
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    chk("tmo_err", bus.timeout_err, 1'b1);
    chk("tmo_sent", bus.sent_cnt, m_sent);
    chk("tmo_idle", bus.busy, 1'b0);
`else
    chk("notmo_err", bus.timeout_err, 1'b0);
    chk("notmo_sent", bus.sent_cnt, m_sent);
    chk("notmo_busy", bus.busy, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
